// File: rtl/md5_pkg.sv
// Shared MD5 constants and packer state type, used by the message packer and md5core.
package md5_pkg;

   localparam int MD5_BLOCK_BITS       = 512;
   localparam int MD5_BLOCK_BYTES      = MD5_BLOCK_BITS / 8;
   localparam int MD5_MAX_SINGLE_BYTES = 55;
   localparam logic [7:0] MD5_PAD_BYTE = 8'h80;
   localparam int MD5_LEN_OFFSET       = 56;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      PAD     = 2'd1,
      SEND    = 2'd2,
      DRAIN   = 2'd3
   } packerState_t;

   // Byte lane 0 sits at the top of the block, matching md5core's word order.
   function automatic int laneMsb(input int lane);
      return MD5_BLOCK_BITS - 1 - 8 * lane;
   endfunction

endpackage

// File: rtl/md5_msg_packer_if.sv
// Byte-stream input and padded-block output bundle of the MD5 message packer.
interface md5_msg_packer_if;
   import md5_pkg::*;

   logic [7:0]                in_data;
   logic                      in_valid;
   logic                      in_last;
   logic                      in_ready;
   logic [MD5_BLOCK_BITS-1:0] mesg;
   logic                      mesg_valid;
   logic                      mesg_ready;
   logic                      err_len;
   logic [15:0]               frames_sent;

   modport master (
      output in_data, in_valid, in_last, mesg_ready,
      input  in_ready, mesg, mesg_valid, err_len, frames_sent
   );

   modport slave (
      input  in_data, in_valid, in_last, mesg_ready,
      output in_ready, mesg, mesg_valid, err_len, frames_sent
   );

endinterface

// File: rtl/md5_msg_packer.sv
// Packs a 1..MAX_LEN byte message into one padded MD5 block (marker, zero fill,
// 64-bit little-endian bit length) and hands it off on a valid/ready pair.
module md5_msg_packer
   import md5_pkg::*;
#(
   parameter int MAX_LEN = MD5_MAX_SINGLE_BYTES
) (
   input  logic clk_12mhz,
   input  logic reset,
   md5_msg_packer_if.slave bus
);

   packerState_t              state_q, state_d;
   logic [5:0]                byteCnt_q, byteCnt_d;
   logic [MD5_BLOCK_BITS-1:0] block_q, block_d;
   logic                      mesgValid_q, mesgValid_d;
   logic                      errLen_q, errLen_d;
   logic [15:0]               frames_q, frames_d;

   logic                      accept;
   logic [8:0]                bitLen;

   assign bus.in_ready    = (state_q == COLLECT) || (state_q == DRAIN);
   assign accept          = bus.in_valid && bus.in_ready;
   assign bitLen          = {byteCnt_q, 3'b000};

   assign bus.mesg        = block_q;
   assign bus.mesg_valid  = mesgValid_q;
   assign bus.err_len     = errLen_q;
   assign bus.frames_sent = frames_q;

   always_ff @(posedge clk_12mhz) begin
      if (reset) begin
         state_q     <= COLLECT;
         byteCnt_q   <= '0;
         block_q     <= '0;
         mesgValid_q <= 1'b0;
         errLen_q    <= 1'b0;
         frames_q    <= '0;
      end else begin
         state_q     <= state_d;
         byteCnt_q   <= byteCnt_d;
         block_q     <= block_d;
         mesgValid_q <= mesgValid_d;
         errLen_q    <= errLen_d;
         frames_q    <= frames_d;
      end
   end

   // The buffer is zeroed on every hand-off or drop, so PAD only has to write
   // the marker and the length; the bytes in between are already zero.
   always_comb begin
      state_d     = state_q;
      byteCnt_d   = byteCnt_q;
      block_d     = block_q;
      mesgValid_d = mesgValid_q;
      errLen_d    = errLen_q;
      frames_d    = frames_q;

      case (state_q)
         COLLECT: begin
            if (accept) begin
               if (byteCnt_q == 6'(MAX_LEN)) begin
                  errLen_d  = 1'b1;
                  block_d   = '0;
                  byteCnt_d = '0;
                  state_d   = bus.in_last ? COLLECT : DRAIN;
               end else begin
                  for (int lane = 0; lane < MAX_LEN; lane++) begin
                     if (byteCnt_q == 6'(lane)) begin
                        block_d[laneMsb(lane) -: 8] = bus.in_data;
                     end
                  end
                  byteCnt_d = byteCnt_q + 6'd1;
                  if (bus.in_last) begin
                     state_d = PAD;
                  end
               end
            end
         end

         PAD: begin
            for (int lane = 1; lane <= MAX_LEN; lane++) begin
               if (byteCnt_q == 6'(lane)) begin
                  block_d[laneMsb(lane) -: 8] = MD5_PAD_BYTE;
               end
            end
            block_d[laneMsb(MD5_LEN_OFFSET) -: 8]     = bitLen[7:0];
            block_d[laneMsb(MD5_LEN_OFFSET + 1) -: 8] = {7'b0, bitLen[8]};
            mesgValid_d = 1'b1;
            state_d     = SEND;
         end

         SEND: begin
            if (bus.mesg_ready) begin
               block_d     = '0;
               byteCnt_d   = '0;
               frames_d    = frames_q + 16'd1;
               mesgValid_d = 1'b0;
               state_d     = COLLECT;
            end
         end

         DRAIN: begin
            if (accept && bus.in_last) begin
               block_d   = '0;
               byteCnt_d = '0;
               state_d   = COLLECT;
            end
         end

         default: begin
            state_d = COLLECT;
         end
      endcase
   end

endmodule

// File: tb/tb_md5_msg_packer.sv
// Self-checking bench for md5_msg_packer: directed cases plus random messages
// compared against a byte-array model of MD5 single-block padding.
module tb_md5_msg_packer;

   typedef byte unsigned byteQ_t[$];

   logic clk_12mhz = 1'b0;
   logic reset     = 1'b1;

   md5_msg_packer_if bus();

   md5_msg_packer dut (
      .clk_12mhz (clk_12mhz),
      .reset     (reset),
      .bus       (bus)
   );

   always #42 clk_12mhz = ~clk_12mhz;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] expFrames = '0;
   logic        expErr    = 1'b0;

   // Pads a message the way MD5 does for one block, working on a plain byte array.
   function automatic logic [511:0] modelBlock(input byteQ_t m);
      byte unsigned    blk[64];
      longint unsigned lenBits;
      logic [511:0]    r;
      foreach (blk[i]) blk[i] = 8'h00;
      foreach (m[i]) blk[i] = m[i];
      blk[m.size()] = 8'h80;
      lenBits = longint'(m.size()) * 8;
      for (int k = 0; k < 8; k++) blk[56 + k] = byte'(lenBits >> (8 * k));
      r = '0;
      for (int i = 0; i < 64; i++) r = {r[503:0], blk[i]};
      return r;
   endfunction

   function automatic byteQ_t strToQ(input string s);
      byteQ_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic byteQ_t fillQ(input int n, input byte unsigned v);
      byteQ_t q;
      for (int i = 0; i < n; i++) q.push_back(v);
      return q;
   endfunction

   function automatic byteQ_t randQ(input int n);
      byteQ_t q;
      for (int i = 0; i < n; i++) q.push_back(byte'($urandom_range(0, 255)));
      return q;
   endfunction

   task automatic checkOutput(input string tag, input logic [511:0] observed,
                              input logic [511:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Feeds bytes with random idle gaps; returns just after the edge taking the final byte.
   task automatic applyStimulus(input byteQ_t m, input bit lastOnFinal);
      for (int i = 0; i < m.size(); i++) begin
         int guard;
         guard = 0;
         @(negedge clk_12mhz);
         while (!bus.in_ready || ($urandom_range(0, 3) == 0)) begin
            bus.in_valid = 1'b0;
            guard++;
            if (guard > 200) begin
               checkOutput("ready_timeout", 512'(bus.in_ready), 512'(1));
               return;
            end
            @(negedge clk_12mhz);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = m[i];
         bus.in_last  = lastOnFinal && (i == m.size() - 1);
         @(posedge clk_12mhz);
      end
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Checks the PAD cycle, the block itself, optional backpressure and the hand-off.
   task automatic expectBlock(input string tag, input logic [511:0] exp, input int holdCycles);
      bus.mesg_ready = (holdCycles == 0);
      @(negedge clk_12mhz);
      checkOutput({tag, "_padValid"}, 512'(bus.mesg_valid), 512'(0));
      checkOutput({tag, "_padReady"}, 512'(bus.in_ready), 512'(0));
      @(negedge clk_12mhz);
      checkOutput({tag, "_valid"}, 512'(bus.mesg_valid), 512'(1));
      checkOutput({tag, "_mesg"}, bus.mesg, exp);
      for (int c = 0; c < holdCycles; c++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'hEE;
         bus.in_last  = 1'b1;
         @(negedge clk_12mhz);
         checkOutput({tag, "_holdValid"}, 512'(bus.mesg_valid), 512'(1));
         checkOutput({tag, "_holdMesg"}, bus.mesg, exp);
         checkOutput({tag, "_holdReady"}, 512'(bus.in_ready), 512'(0));
      end
      bus.in_valid   = 1'b0;
      bus.in_last    = 1'b0;
      bus.mesg_ready = 1'b1;
      expFrames      = expFrames + 16'd1;
      @(negedge clk_12mhz);
      checkOutput({tag, "_doneValid"}, 512'(bus.mesg_valid), 512'(0));
      checkOutput({tag, "_doneReady"}, 512'(bus.in_ready), 512'(1));
      checkOutput({tag, "_frames"}, 512'(bus.frames_sent), 512'(expFrames));
      checkOutput({tag, "_err"}, 512'(bus.err_len), 512'(expErr));
   endtask

   initial begin
      #(84 * 20000);
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      byteQ_t m;

      bus.in_data    = 8'h00;
      bus.in_valid   = 1'b0;
      bus.in_last    = 1'b0;
      bus.mesg_ready = 1'b1;
      repeat (3) @(posedge clk_12mhz);
      @(negedge clk_12mhz);
      reset = 1'b0;
      checkOutput("rst_ready", 512'(bus.in_ready), 512'(1));
      checkOutput("rst_valid", 512'(bus.mesg_valid), 512'(0));
      checkOutput("rst_mesg", bus.mesg, 512'(0));
      checkOutput("rst_err", 512'(bus.err_len), 512'(0));
      checkOutput("rst_frames", 512'(bus.frames_sent), 512'(0));

      applyStimulus(strToQ("The quick brown fox jumps over the lazy dog"), 1'b1);
      expectBlock("fox", 512'h54686520_71756963_6b206272_6f776e20_666f7820_6a756d70_73206f76_65722074_6865206c_617a7920_646f6780_00000000_00000000_00000000_58010000_00000000, 0);

      applyStimulus(strToQ("a"), 1'b1);
      expectBlock("single", {16'h6180, 432'h0, 8'h08, 56'h0}, 0);

      m = fillQ(55, 8'h41);
      applyStimulus(m, 1'b1);
      expectBlock("max55", modelBlock(m), 0);

      for (int r = 0; r < 6; r++) begin
         m = randQ($urandom_range(1, 55));
         applyStimulus(m, 1'b1);
         expectBlock($sformatf("rand%0d_len%0d", r, m.size()), modelBlock(m), 0);
      end

      applyStimulus(fillQ(56, 8'h41), 1'b1);
      expErr = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_12mhz);
         checkOutput("over56_noValid", 512'(bus.mesg_valid), 512'(0));
      end
      checkOutput("over56_err", 512'(bus.err_len), 512'(1));
      checkOutput("over56_frames", 512'(bus.frames_sent), 512'(expFrames));
      applyStimulus(strToQ("a"), 1'b1);
      expectBlock("afterOver", {16'h6180, 432'h0, 8'h08, 56'h0}, 0);

      applyStimulus(fillQ(60, 8'h5A), 1'b1);
      @(negedge clk_12mhz);
      checkOutput("drain_noValid", 512'(bus.mesg_valid), 512'(0));
      checkOutput("drain_ready", 512'(bus.in_ready), 512'(1));
      checkOutput("drain_frames", 512'(bus.frames_sent), 512'(expFrames));
      applyStimulus(strToQ("abc"), 1'b1);
      expectBlock("abc", {32'h61626380, 416'h0, 8'h18, 56'h0}, 0);

      m = randQ($urandom_range(1, 55));
      applyStimulus(m, 1'b1);
      expectBlock("backpressure", modelBlock(m), 5);
      m = randQ($urandom_range(1, 55));
      applyStimulus(m, 1'b1);
      expectBlock("afterHold", modelBlock(m), 0);

      applyStimulus(randQ(10), 1'b0);
      @(negedge clk_12mhz);
      reset = 1'b1;
      @(negedge clk_12mhz);
      reset     = 1'b0;
      expFrames = '0;
      expErr    = 1'b0;
      checkOutput("midRst_valid", 512'(bus.mesg_valid), 512'(0));
      checkOutput("midRst_mesg", bus.mesg, 512'(0));
      checkOutput("midRst_err", 512'(bus.err_len), 512'(0));
      checkOutput("midRst_frames", 512'(bus.frames_sent), 512'(0));
      checkOutput("midRst_ready", 512'(bus.in_ready), 512'(1));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_12mhz);
         checkOutput("midRst_noValid", 512'(bus.mesg_valid), 512'(0));
      end
      m = randQ(20);
      applyStimulus(m, 1'b1);
      expectBlock("afterRst", modelBlock(m), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/md5_msg_packer.md
Name: md5_msg_packer

Overview:
Front end for the md5core hash pipeline. It accepts a message as a byte stream with a valid/ready handshake and assembles one padded 512-bit MD5 block: data bytes, the 0x80 marker, zero fill, and a 64-bit little-endian bit length. It presents that block on a valid/ready output whose mesg/mesg_valid pair drives md5core mesg/valid_in directly. Scope is single-block messages only, 1..MAX_LEN bytes.

Parameters:
MAX_LEN, 55, maximum accepted message length in bytes; legal range 1..55 (single-block limit).

Ports:
clk_12mhz  in  1  system clock
reset  in  1  synchronous, active-high reset
in_data  in  8  message byte
in_valid  in  1  in_data valid
in_last  in  1  qualifies the final byte of a message
in_ready  out  1  packer accepts a byte this cycle
mesg  out  512  padded block; byte i occupies mesg[511-8*i -: 8]
mesg_valid  out  1  mesg holds a complete block
mesg_ready  in  1  consumer takes the block (tie high for md5core)
err_len  out  1  sticky flag: a message exceeded MAX_LEN
frames_sent  out  16  count of blocks handed off, wraps at 0xFFFF

Behaviour:
- Reset and clock: reset is synchronous, active-high; the clock is clk_12mhz.
- Reset values: state=COLLECT, byte count=0, mesg=0, mesg_valid=0, err_len=0, frames_sent=0, in_ready=1 from the first cycle after reset.
- Reset mid-operation: abandons any partial or pending block with no output; all registers return to reset values.
- Byte accept rule: a byte is accepted when in_valid && in_ready at a rising edge.
- State machine: COLLECT, PAD, SEND, DRAIN.
- COLLECT, in_ready=1:
  - An accepted byte is written at index cnt; cnt increments.
  - If the byte has in_last set, go to PAD.
  - If the byte is accepted with cnt==MAX_LEN (the (MAX_LEN+1)th byte), set err_len. Then go to DRAIN if in_last=0, or straight to COLLECT with the buffer cleared if in_last=1. No block is emitted.
- PAD, in_ready=0, one cycle:
  - Write 0x80 at index cnt.
  - Write L=cnt*8 (9 bits, max 440) little-endian: byte56=L[7:0], byte57={7'b0,L[8]}; bytes 58..63=0.
  - Bytes between the marker and 56 are already zero, because the buffer is cleared on every block hand-off or drop.
  - Go to SEND.
- SEND, in_ready=0:
  - mesg_valid=1, and mesg is held stable.
  - On mesg_valid && mesg_ready: clear the buffer, cnt=0, frames_sent+=1, mesg_valid=0 next cycle, go to COLLECT.
  - mesg_valid is never deasserted without a handshake.
- DRAIN, in_ready=1: discard bytes until one with in_last is accepted, then clear the buffer, cnt=0, go to COLLECT.
- Latency: the edge accepting the last byte enters PAD; the next edge loads padding and raises mesg_valid. mesg_valid is high 1 cycle after the last-byte edge. With mesg_ready=1 the handshake completes 1 cycle later, so a new message's first byte can be accepted 3 edges after the previous last byte.
- Empty messages are not supported; in_last always accompanies a byte.
- in_data and in_last are ignored when in_ready=0.
- err_len clears only on reset.
- All outputs are registered except in_ready, which is decoded from state.

Decomposition:
- Shared package md5_pkg:
  - MD5_BLOCK_BITS=512
  - MD5_MAX_SINGLE_BYTES=55
  - MD5_PAD_BYTE=8'h80
  - MD5_LEN_OFFSET=56
  - state encoding constants for COLLECT, PAD, SEND, DRAIN
- md5core uses the same block constant.
- No sub-module; the byte-lane write decoder and length insert are small enough to live inline.

Test Plan:
1. "The quick brown fox jumps over the lazy dog" (43 bytes), mesg_ready=1 -> mesg = 512'h54686520_71756963_6b206272_6f776e20_666f7820_6a756d70_73206f76_65722074_6865206c_617a7920_646f6780_00000000_00000000_00000000_58010000_00000000. mesg_valid is high exactly 1 cycle; feeding mesg to md5core yields digest 9e107d9d372bb6826bd81d3542a419d6.
2. Single byte 0x61 ("a") with in_last -> mesg[511:496]=16'h6180, byte56=0x08, all other bytes 0. mesg_valid rises 1 cycle after the accepting edge. frames_sent=1.
3. 55 bytes of 0x41 -> bytes 0..54=0x41, byte55=0x80, byte56=0xB8, byte57=0x01, err_len=0.
4. 56 bytes of 0x41, last on the 56th -> err_len=1, no mesg_valid. A following "a" message produces exactly the block of test 2, and frames_sent increments by 1 only.
5. 60-byte message with in_last on the 60th byte -> DRAIN consumes bytes 57..60 with in_ready=1. Then an immediate 3-byte message "abc" -> mesg = 0x61626380, byte56=0x18.
6. Backpressure: hold mesg_ready=0 for 5 cycles during SEND -> mesg_valid held and mesg bit-stable, in_ready=0, upstream bytes not consumed. Pulse reset during a 20-byte message -> mesg_valid stays 0 and the next message packs correctly.
